lsu: RTL and testbench
======================

# lsu

Parametrised load/store unit sitting in the core's memory stage between the execute stage and the data-side buses. Accepts one load or store per request with byte, halfword or word size, and routes it either to the local block RAM or to an AXI4-Lite MMIO master according to the address map. Performs byte-lane steering, write strobes and sign/zero extension. Returns one tagged response per request.

## Interface
Parameters:
- RAM_AW, 17: RAM word-address width; RAM covers byte addresses [0, 4·2^RAM_AW).
- RAM_LAT, 1: RAM read latency in cycles, legal 1..3.
- MMIO_TOP, 8'h7F: value of addr[31:24] that selects MMIO.
- TAG_W, 5: width of request/response tag.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid / req_ready  in / out  1  request handshake.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr, req_wdata  in  32  byte address; store data, LSB-aligned.
- req_tag  in  TAG_W  returned unchanged on resp_tag.
- resp_valid / resp_ready  out / in  1  response handshake.
- resp_data  out  32  extended load data; 0 for stores; faulting address on error.
- resp_err  out  1  bus error or misalignment.
- resp_tag  out  TAG_W.
- ram_en, ram_we, ram_addr, ram_din  out  1, 4, RAM_AW, 32.
- ram_dout  in  32.
- m_axi_*  AXI4-Lite master, 32-bit address/data: aw/w/b/ar/r channels; prot = 3'b000.

## Operation
- States: IDLE, RAM_WAIT, AXI_WR, AXI_B, AXI_AR, AXI_R, RESP.
- IDLE: req_ready=1. On accept, latch all request fields. Select MMIO if addr[31:24]==MMIO_TOP, else RAM.
- RAM: ram_addr=addr[RAM_AW+1:2]; ram_en=1 for one cycle; ram_we=lane mask for stores, 0 for loads. Go to RAM_WAIT, count RAM_LAT cycles, then capture ram_dout and go to RESP.
- Lane mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Write data replicated: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load extract: shift the selected lane down; sign-extend unless req_unsigned; word is passed through.
- MMIO store: assert awvalid and wvalid together, with awaddr=addr, wstrb=lane mask and replicated wdata. Drop each valid independently on its handshake.
- When both valids are done, move to AXI_B with bready=1. On bvalid: err=(bresp!=0), go to RESP.
- MMIO load: arvalid with araddr=addr until arready, then AXI_R with rready=1. On rvalid, extract lanes from rdata, set err=(rresp!=0), go to RESP.
- RESP: resp_valid=1 and held, with all resp_* fields stable, until resp_ready. Then go to IDLE. resp_data=0 when err on an AXI access.
- rst at any cycle: immediately returns to IDLE and abandons any AXI transaction in flight. The interconnect is reset by the same rst.

## Timing
- Reset values: req_ready=0 while rst=1. Every other output is 0, including all m_axi valids/readys, ram_en, ram_we and resp_*.
- RAM access: accept in cycle 0; ram_en in cycle 1; resp_valid in cycle 1+RAM_LAT. Loads and stores have the same latency.
- Back-to-back throughput: one request per 2+RAM_LAT cycles when resp_ready is held at 1.
- MMIO latency is set by the slave. At minimum, resp_valid comes 3 cycles after accept.
- A response and the next accept never overlap; req_ready=0 outside IDLE.

## Configuration
- Macro LSU_MISALIGN_EXC_EN.
- Defined:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned request issues no RAM or AXI access and goes directly to RESP.
  - Response is resp_err=1 and resp_data=req_addr, with resp_valid in cycle 1.
- Undefined: the low address bits are cleared to the natural alignment (word: [1:0], half: [0]) and the access proceeds normally.

## Structure
- Package lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W);
  - state enum;
  - function lane_mask(size, addr[1:0]);
  - function wdata_rep(size, data);
  - function load_extract(size, unsigned, addr[1:0], word).
- One sub-module, lsu_lane_align: registered load-extract stage shared by the RAM and AXI read paths.

## Test plan
- RAM sw 0xDEADBEEF @0x100, then lw @0x100: one write with ram_we=4'b1111 and ram_addr=0x40; the load returns 0xDEADBEEF with resp_valid at cycle 1+RAM_LAT.
- sb 0x80 @0x203, then lb and lbu @0x203: ram_we=4'b1000 and din=0x80808080; lb returns 0xFFFFFF80, lbu returns 0x00000080.
- MMIO sb 0x41 @0x7F000004, with awready delayed 3 cycles and wready given immediately: wstrb=4'b0001 and wdata=0x41414141; awvalid stays asserted until handshake; response follows bvalid.
- MMIO lw @0x7F000000 with rresp=2'b10: resp_err=1 and resp_data=0.
- lh @0x101: with LSU_MISALIGN_EXC_EN, resp_err=1, resp_data=0x101 and no ram_en; without it, an access at 0x100 with no error.
- resp_ready held 0 for 5 cycles, then rst asserted: resp_* stay stable until rst; after rst all outputs are 0, and req_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane-steering helpers for the load/store unit.
// Helpers cover write-strobe generation, store-data replication and load extraction.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RAM_WAIT,
        AXI_WR,
        AXI_B,
        AXI_AR,
        AXI_R,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RK_ZERO,
        RK_LOAD,
        RK_ADDR
    } resp_kind_t;

    function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = 4'b0011 << {off[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input size_t size, input logic [31:0] data);
        case (size)
            SZ_B:    wdata_rep = {4{data[7:0]}};
            SZ_H:    wdata_rep = {2{data[15:0]}};
            default: wdata_rep = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input size_t size, input logic is_unsigned,
                                                 input logic [1:0] off, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    load_extract = is_unsigned ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    load_extract = is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Registered load-extract stage: steers the addressed lane down and extends it.
// Shared by the RAM and AXI read paths; holds its value until the next capture.
module lsu_lane_align import lsu_pkg::*; (
    input  logic        clk,
    input  logic        en,
    input  size_t       size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data_p1
);

    // stage p0 -> p1: extracted load data
    always_ff @(posedge clk) begin
        if (en) begin
            data_p1 <= load_extract(size, is_unsigned, off, word);
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit routing each request to local block RAM or an AXI4-Lite MMIO master.
// Optional macro LSU_MISALIGN_EXC_EN: misaligned requests fault instead of being aligned down.
// ram_dout is sampled in the RAM_LAT-th cycle counting the ram_en cycle as the first.
module lsu import lsu_pkg::*; #(
    parameter int          RAM_AW   = 17,
    parameter int          RAM_LAT  = 1,
    parameter logic [7:0]  MMIO_TOP = 8'h7F,
    parameter int          TAG_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [31:0]       m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    state_t             state, state_nxt;
    logic [1:0]         cnt;
    logic               aw_done, w_done, err_q;
    resp_kind_t         kind_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         mask_q;
    size_t              size_q;
    logic               uns_q, store_q;
    logic [TAG_W-1:0]   tag_q;
    size_t              req_sz;
    logic               bad, accept, is_mmio, capture;
    logic [31:0]        addr_use, cap_word, align_data;

    assign req_sz  = (req_size == 2'd3) ? SZ_W : size_t'(req_size);
    assign is_mmio = (req_addr[31:24] == MMIO_TOP);

`ifdef LSU_MISALIGN_EXC_EN
    assign bad      = (req_sz == SZ_H && req_addr[0]) || (req_sz == SZ_W && req_addr[1:0] != 2'b00);
    assign addr_use = req_addr;
`else
    assign bad = 1'b0;
    always_comb begin
        addr_use = req_addr;
        if (req_sz == SZ_W) begin
            addr_use[1:0] = 2'b00;
        end else if (req_sz == SZ_H) begin
            addr_use[0] = 1'b0;
        end
    end
`endif

    assign req_ready    = (state == IDLE) && !rst;
    assign accept       = req_valid && req_ready;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_comb begin
        state_nxt     = state;
        ram_en        = 1'b0;
        ram_we        = 4'b0000;
        ram_addr      = '0;
        ram_din       = '0;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = 4'b0000;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_rready  = 1'b0;
        resp_valid    = 1'b0;
        capture       = 1'b0;
        cap_word      = ram_dout;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)          state_nxt = RESP;
                    else if (is_mmio) state_nxt = req_store ? AXI_WR : AXI_AR;
                    else              state_nxt = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (cnt == 2'd0) begin
                    ram_en   = 1'b1;
                    ram_we   = store_q ? mask_q : 4'b0000;
                    ram_addr = addr_q[RAM_AW+1:2];
                    ram_din  = wdata_q;
                end
                if (cnt == 2'(RAM_LAT - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            AXI_WR: begin
                // address and data channels complete independently
                m_axi_awvalid = !aw_done;
                m_axi_awaddr  = addr_q;
                m_axi_wvalid  = !w_done;
                m_axi_wdata   = wdata_q;
                m_axi_wstrb   = mask_q;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
                    state_nxt = AXI_B;
                end
            end
            AXI_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = RESP;
            end
            AXI_AR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = addr_q;
                if (m_axi_arready) state_nxt = AXI_R;
            end
            AXI_R: begin
                m_axi_rready = 1'b1;
                cap_word     = m_axi_rdata;
                if (m_axi_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
            kind_q  <= RK_ZERO;
        end else begin
            state   <= state_nxt;
            cnt     <= (state == RAM_WAIT && state_nxt == RAM_WAIT) ? cnt + 2'd1 : 2'd0;
            aw_done <= (state == AXI_WR) && (aw_done || (m_axi_awvalid && m_axi_awready));
            w_done  <= (state == AXI_WR) && (w_done || (m_axi_wvalid && m_axi_wready));
            if (accept) begin
                err_q  <= bad;
                kind_q <= bad ? RK_ADDR : (req_store ? RK_ZERO : RK_LOAD);
            end else if ((state == AXI_B && m_axi_bvalid) || (state == AXI_R && m_axi_rvalid)) begin
                // a faulting bus access returns zero data
                err_q <= (state == AXI_B) ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00);
                if ((state == AXI_B) ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00)) begin
                    kind_q <= RK_ZERO;
                end
            end
        end
    end

    // stage p0: request fields latched on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr_use;
            wdata_q <= wdata_rep(req_sz, req_wdata);
            mask_q  <= lane_mask(req_sz, addr_use[1:0]);
            size_q  <= req_sz;
            uns_q   <= req_unsigned;
            store_q <= req_store;
            tag_q   <= req_tag;
        end
    end

    lsu_lane_align u_align (
        .clk         (clk),
        .en          (capture),
        .size        (size_q),
        .is_unsigned (uns_q),
        .off         (addr_q[1:0]),
        .word        (cap_word),
        .data_p1     (align_data)
    );

    always_comb begin
        resp_data = '0;
        if (state == RESP) begin
            case (kind_q)
                RK_LOAD: resp_data = align_data;
                RK_ADDR: resp_data = addr_q;
                default: resp_data = '0;
            endcase
        end
    end

    assign resp_err = (state == RESP) && err_q;
    assign resp_tag = (state == RESP) ? tag_q : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: RAM and MMIO paths, lane steering, errors, reset.
// Honours LSU_MISALIGN_EXC_EN when the design is built with it.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [16:0] ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:131071];

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
        end
    end

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .resp_tag(resp_tag),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{req_ready, resp_valid, resp_data, resp_err, resp_tag, ram_en, ram_we, ram_addr,
                 ram_din, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot,
                 arvalid, rready};
    endfunction

    // presents a request in the current cycle; returns one cycle after the accept
    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d; req_tag = t; req_valid = 1'b1;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0; resp_ready = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        tick(); tick();
        chk("reset_outputs_zero", {31'b0, any_out()}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // RAM word store then load
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1);
        chk("sw_ram_en", {31'b0, ram_en}, 32'd1);
        chk("sw_ram_we", {28'b0, ram_we}, 32'hF);
        chk("sw_ram_addr", {15'b0, ram_addr}, 32'h40);
        chk("sw_ram_din", ram_din, 32'hDEAD_BEEF);
        tick();
        chk("sw_resp", {resp_valid, resp_err, resp_tag, 25'b0}, {1'b1, 1'b0, 5'd1, 25'b0});
        chk("sw_resp_data", resp_data, 32'h0);
        tick();
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd2);
        chk("lw_ram_en_we", {27'b0, ram_en, ram_we}, {27'b0, 1'b1, 4'b0000});
        chk("lw_not_yet_valid", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("lw_resp_valid_tag", {26'b0, resp_valid, resp_tag}, {26'b0, 1'b1, 5'd2});
        chk("lw_resp_data", resp_data, 32'hDEAD_BEEF);
        tick();

        // halfword and byte loads from the same word
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 5'd3);
        tick();
        chk("lh_upper", resp_data, 32'hFFFF_DEAD);
        tick();
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 5'd4);
        tick();
        chk("lhu_upper", resp_data, 32'h0000_DEAD);
        tick();
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 5'd5);
        tick();
        chk("lb_byte1", resp_data, 32'hFFFF_FFBE);
        tick();

        // byte store to lane 3, then signed and unsigned byte loads
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_0080, 5'd6);
        chk("sb_ram_we", {28'b0, ram_we}, 32'b1000);
        chk("sb_ram_din", ram_din, 32'h8080_8080);
        chk("sb_ram_addr", {15'b0, ram_addr}, 32'h80);
        tick(); tick();
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0, 5'd7);
        tick();
        chk("lb_sign", resp_data, 32'hFFFF_FF80);
        tick();
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0, 5'd8);
        tick();
        chk("lbu_zero", resp_data, 32'h0000_0080);
        tick();

        // MMIO byte store, awready delayed, wready immediate
        wready = 1'b1;
        issue(1'b1, 2'd0, 1'b0, 32'h7F00_0004, 32'h0000_0041, 5'd9);
        chk("mmio_sb_valids", {30'b0, awvalid, wvalid}, 32'b11);
        chk("mmio_sb_awaddr", awaddr, 32'h7F00_0004);
        chk("mmio_sb_wstrb", {28'b0, wstrb}, 32'b0001);
        chk("mmio_sb_wdata", wdata, 32'h4141_4141);
        tick();
        wready = 1'b0;
        chk("mmio_aw_held_c2", {30'b0, awvalid, wvalid}, 32'b10);
        tick();
        chk("mmio_aw_held_c3", {30'b0, awvalid, wvalid}, 32'b10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("mmio_b_phase", {29'b0, awvalid, bready, resp_valid}, 32'b010);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("mmio_sb_resp", {resp_valid, resp_err, resp_tag, 25'b0}, {1'b1, 1'b0, 5'd9, 25'b0});
        tick();

        // MMIO word load with slave error
        arready = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h7F00_0000, 32'h0, 5'd10);
        chk("mmio_lw_ar", {31'b0, arvalid}, 32'd1);
        chk("mmio_lw_araddr", araddr, 32'h7F00_0000);
        tick();
        arready = 1'b0;
        chk("mmio_lw_rready", {30'b0, arvalid, rready}, 32'b01);
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("mmio_lw_err", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("mmio_lw_err_data", resp_data, 32'h0);
        tick();

        // MMIO signed byte load, good response
        arready = 1'b1;
        issue(1'b0, 2'd0, 1'b0, 32'h7F00_0002, 32'h0, 5'd11);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h00AB_0000;
        tick();
        rvalid = 1'b0;
        chk("mmio_lb_data", resp_data, 32'hFFFF_FFAB);
        chk("mmio_lb_err", {31'b0, resp_err}, 32'd0);
        tick();

        // misaligned halfword load
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0, 5'd12);
`ifdef LSU_MISALIGN_EXC_EN
        chk("mis_no_ram_en", {31'b0, ram_en}, 32'd0);
        chk("mis_resp", {30'b0, resp_valid, resp_err}, 32'b11);
        chk("mis_resp_data", resp_data, 32'h0000_0101);
        tick();
`else
        chk("mis_ram_en", {31'b0, ram_en}, 32'd1);
        chk("mis_ram_addr", {15'b0, ram_addr}, 32'h40);
        tick();
        chk("mis_resp", {30'b0, resp_valid, resp_err}, 32'b10);
        chk("mis_resp_data", resp_data, 32'hFFFF_BEEF);
        tick();
`endif

        // response held under backpressure, then reset
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd13);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid_tag", {26'b0, resp_valid, resp_tag}, {26'b0, 1'b1, 5'd13});
            chk("hold_data", resp_data, 32'hDEAD_BEEF);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("rst_outputs_zero", {31'b0, any_out()}, 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("ready_after_rst_falls", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
